// File: rtl/ram_delay_pkg.sv
// Shared widths and helpers for the sample-count delay line.
// Build option: RAM_DELAY_EXT_ADDR_EN enables the external RAM address path.
package ram_delay_pkg;

  localparam int DEF_NBITS_DATA = 42;
  localparam int DEF_NBITS_ADDR = 9;

  // n = 0 selects the whole RAM as the delay.
  function automatic int unsigned eff_depth(
    input int unsigned n,
    input int unsigned aw
  );
    return (n == 0) ? (32'd1 << aw) : n;
  endfunction

endpackage

// File: rtl/ram_delay_ram.sv
// Single-port read-first synchronous RAM, no reset (block-RAM friendly).
// The read port only updates on a write, so dout holds across idle cycles.
module ram_delay_ram #(
  parameter int DW = 42,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      dout      <= mem[addr];
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/ram_delay.sv
// Programmable sample-count delay line over a circular RAM buffer.
// Build option: RAM_DELAY_EXT_ADDR_EN lets addr_en/addr override wptr.
module ram_delay
  import ram_delay_pkg::*;
#(
  parameter int P_NBITS_DATA = DEF_NBITS_DATA,
  parameter int P_NBITS_ADDR = DEF_NBITS_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [P_NBITS_ADDR-1:0] n,
  input  logic                    wr,
  input  logic [P_NBITS_DATA-1:0] d,
  input  logic                    addr_en,
  input  logic [P_NBITS_ADDR-1:0] addr,
  output logic [P_NBITS_DATA-1:0] qn,
  output logic [P_NBITS_DATA-1:0] qo,
  output logic                    valid
);

  localparam int FW = P_NBITS_ADDR + 1;

  logic [P_NBITS_ADDR-1:0] wptr;
  logic [P_NBITS_ADDR-1:0] ram_addr;
  logic [FW-1:0]           fill;
  logic [FW-1:0]           depth;
  logic [FW-1:0]           depth_m1;
  logic [P_NBITS_DATA-1:0] ram_q;
  logic                    qo_live;
  logic                    wr_ok;
  logic                    full;
  logic                    wrap;

  assign depth    = FW'(eff_depth(32'(n), P_NBITS_ADDR));
  assign depth_m1 = depth - FW'(1);
  assign wr_ok    = wr & ~flush;
  assign full     = (fill == depth);
  assign wrap     = ({1'b0, wptr} == depth_m1);

`ifdef RAM_DELAY_EXT_ADDR_EN
  assign ram_addr = addr_en ? addr : wptr;
`else
  logic unused_ext;
  assign unused_ext = ^{addr_en, addr};
  assign ram_addr   = wptr;
`endif

  ram_delay_ram #(
    .DW(P_NBITS_DATA),
    .AW(P_NBITS_ADDR)
  ) u_ram (
    .clk (clk),
    .we  (wr_ok),
    .addr(ram_addr),
    .din (d),
    .dout(ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      fill  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      fill  <= '0;
      valid <= 1'b0;
    end else if (wr) begin
      wptr  <= wrap ? '0 : wptr + 1'b1;
      fill  <= full ? fill : fill + 1'b1;
      valid <= full;
    end else begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qn      <= '0;
      qo_live <= 1'b0;
    end else if (wr_ok) begin
      qn      <= d;
      qo_live <= 1'b1;
    end
  end

  // RAM read port has no reset; gate it so qo reads 0 until the next write.
  assign qo = qo_live ? ram_q : '0;

endmodule

// File: tb/tb_ram_delay.sv
// Self-checking bench for ram_delay: directed scenarios plus random traffic
// checked against a queue-based history model of the delay line.
module tb_ram_delay;

  localparam int DW = 42;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          addr_en = 1'b0;
  logic [AW-1:0] n = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] d = '0;
  logic [DW-1:0] qn;
  logic [DW-1:0] qo;
  logic          valid;

  logic          flush1 = 1'b0;
  logic          wr1 = 1'b0;
  logic          addr_en1 = 1'b0;
  logic [3:0]    n1 = '0;
  logic [3:0]    addr1 = '0;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] qn1;
  logic [DW-1:0] qo1;
  logic          valid1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] hist[$];
  int            cnt = 0;
  logic [DW-1:0] exp_qn = '0;
  logic [DW-1:0] exp_qo = '0;
  logic          exp_valid = 1'b0;

  always #5 clk = ~clk;

  ram_delay #(.P_NBITS_DATA(DW), .P_NBITS_ADDR(AW)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .n(n), .wr(wr), .d(d),
    .addr_en(addr_en), .addr(addr), .qn(qn), .qo(qo), .valid(valid)
  );

  ram_delay #(.P_NBITS_DATA(DW), .P_NBITS_ADDR(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush1), .n(n1), .wr(wr1), .d(d1),
    .addr_en(addr_en1), .addr(addr1), .qn(qn1), .qo(qo1), .valid(valid1)
  );

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic model_clear();
    cnt = 0;
    hist.delete();
    exp_valid = 1'b0;
  endtask

  // One clock of u0 stimulus; the model tracks "sample written depth writes ago".
  task automatic cyc(input logic w, input logic [DW-1:0] dd,
                     input logic f, input logic [AW-1:0] a);
    int dep;
    wr = w; d = dd; flush = f; addr = a;
    @(posedge clk);
    #1;
    dep = (n == 0) ? (1 << AW) : int'(n);
    if (f) begin
      model_clear();
    end else if (w) begin
      exp_valid = (cnt >= dep);
      if (exp_valid) exp_qo = hist[hist.size() - dep];
      hist.push_back(dd);
      if (hist.size() > (1 << AW)) void'(hist.pop_front());
      cnt++;
      exp_qn = dd;
    end else begin
      exp_valid = 1'b0;
    end
    wr = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (qn !== '0 || qo !== '0 || valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset qn=%h qo=%h valid=%b want 0", qn, qo, valid);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    exp_qn = '0;
    model_clear();
  endtask

  task automatic test_fill();
    n = 16;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, DW'(i), 1'b0, '0);
      n_cmp++;
      if (valid !== (i >= 16) || qn !== DW'(i)) begin
        n_bad++;
        $display("FAIL fill i=%0d valid=%b qn=%0d want %b %0d", i, valid, qn, i >= 16, i);
      end
      if (i >= 16) begin
        n_cmp++;
        if (qo !== DW'(i - 16)) begin
          n_bad++;
          $display("FAIL fill_qo i=%0d qo=%0d want %0d", i, qo, i - 16);
        end
      end
    end
  endtask

  task automatic test_gapped();
    int v;
    logic [DW-1:0] last_qn;
    v = 0;
    n = 16;
    cyc(1'b0, '0, 1'b1, '0);
    last_qn = '1;
    for (int g = 1; g <= 5; g++) begin
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < 4; k++) begin
          cyc(1'b1, DW'(v), 1'b0, '0);
          v++;
          n_cmp++;
          if (valid !== exp_valid || qn !== exp_qn) begin
            n_bad++;
            $display("FAIL gap_w valid=%b qn=%0d want %b %0d", valid, qn, exp_valid, exp_qn);
          end
          if (exp_valid) begin
            n_cmp++;
            if (qo !== qn - 16 || (last_qn != '1 && qn !== last_qn + 1)) begin
              n_bad++;
              $display("FAIL gap_qo qo=%0d qn=%0d want qo=%0d", qo, qn, qn - 16);
            end
            last_qn = qn;
          end
          if (g == 5) break;
        end
        for (int k = 0; k < ((g == 5) ? 1 : g); k++) begin
          cyc(1'b0, rnd(), 1'b0, '0);
          n_cmp++;
          if (valid !== 1'b0 || qn !== exp_qn) begin
            n_bad++;
            $display("FAIL gap_idle valid=%b qn=%0d want 0 %0d", valid, qn, exp_qn);
          end
        end
      end
    end
  endtask

  task automatic test_ext_addr();
    n = 16;
    addr_en = 1'b1;
    cyc(1'b0, '0, 1'b1, '0);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, rnd(), 1'b0, AW'((k + 1) % 16));
      n_cmp++;
      if (valid !== exp_valid || qn !== exp_qn) begin
        n_bad++;
        $display("FAIL ext valid=%b qn=%h want %b %h", valid, qn, exp_valid, exp_qn);
      end
      if (exp_valid) begin
        n_cmp++;
        if (qo !== exp_qo) begin
          n_bad++;
          $display("FAIL ext_qo qo=%h want %h", qo, exp_qo);
        end
      end
    end
    addr_en = 1'b0;
  endtask

  task automatic test_flush();
    n = 16;
    for (int k = 0; k < 20; k++) cyc(1'b1, '1, 1'b0, '0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, rnd(), 1'b1, '0);
      n_cmp++;
      if (valid !== 1'b0 || qn !== {DW{1'b1}}) begin
        n_bad++;
        $display("FAIL flush valid=%b qn=%h want 0 all-ones", valid, qn);
      end
    end
    for (int k = 0; k < 17; k++) begin
      cyc(1'b1, rnd(), 1'b0, '0);
      n_cmp++;
      if (valid !== (k == 16) || qn !== exp_qn) begin
        n_bad++;
        $display("FAIL post_flush k=%0d valid=%b want %b", k, valid, k == 16);
      end
    end
  endtask

  task automatic test_reset_mid();
    n = 16;
    for (int k = 0; k < 20; k++) cyc(1'b1, rnd(), 1'b0, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (qn !== '0 || qo !== '0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid qn=%h qo=%h valid=%b want 0", qn, qo, valid);
    end
    exp_qn = '0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      cyc(1'b1, rnd(), 1'b0, '0);
      n_cmp++;
      if (valid !== (k == 16) || qn !== exp_qn) begin
        n_bad++;
        $display("FAIL rst_refill k=%0d valid=%b want %b", k, valid, k == 16);
      end
      if (k == 16) begin
        n_cmp++;
        if (qo !== exp_qo) begin
          n_bad++;
          $display("FAIL rst_refill_qo qo=%h want %h", qo, exp_qo);
        end
      end
    end
  endtask

  task automatic test_wrap();
    n1 = '0;
    for (int k = 0; k <= 16; k++) begin
      wr1 = 1'b1;
      d1 = DW'(k);
      @(posedge clk); #1;
      n_cmp++;
      if (valid1 !== (k == 16) || qn1 !== DW'(k)) begin
        n_bad++;
        $display("FAIL wrap k=%0d valid=%b qn=%0d want %b %0d", k, valid1, qn1, k == 16, k);
      end
      if (k == 16) begin
        n_cmp++;
        if (qo1 !== '0) begin
          n_bad++;
          $display("FAIL wrap_qo qo=%0d want 0", qo1);
        end
      end
    end
    wr1 = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      n = (r == 4) ? '0 : AW'($urandom_range(1, 40));
      cyc(1'b0, '0, 1'b1, '0);
      for (int k = 0; k < ((r == 4) ? 700 : 200); k++) begin
        cyc(($urandom_range(0, 9) < 7), rnd(),
            (r != 4) && ($urandom_range(0, 99) < 2), '0);
        n_cmp++;
        if (valid !== exp_valid || qn !== exp_qn) begin
          n_bad++;
          $display("FAIL rnd n=%0d valid=%b qn=%h want %b %h", n, valid, qn, exp_valid, exp_qn);
        end
        if (exp_valid) begin
          n_cmp++;
          if (qo !== exp_qo) begin
            n_bad++;
            $display("FAIL rnd_qo n=%0d qo=%h want %h", n, qo, exp_qo);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gapped();
    test_ext_addr();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_delay.md
# ram_delay

Programmable-length delay line built on a single-port-style circular RAM buffer. Each accepted write stores a sample and, one cycle later, presents both that newest sample and the sample written exactly `n` writes earlier. It sits in datapaths that need a sample-count delay (not a clock-count delay), such as running-sum or baseline pipelines fed by a gated sample strobe.

## Interface

**Parameters**
- `P_NBITS_DATA`, default 42: sample width.
- `P_NBITS_ADDR`, default 9: RAM address width. RAM depth is 2^`P_NBITS_ADDR`.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `flush`, in, 1: synchronous clear of pointer and fill state.
- `n`, in, `P_NBITS_ADDR`: delay length in writes.
- `wr`, in, 1: write strobe; one sample per high cycle.
- `d`, in, `P_NBITS_DATA`: sample in.
- `addr_en`, in, 1: use `addr` instead of the internal write pointer.
- `addr`, in, `P_NBITS_ADDR`: external RAM address.
- `qn`, out, `P_NBITS_DATA`: newest sample, i.e. the last accepted `d`.
- `qo`, out, `P_NBITS_DATA`: sample written `n` writes before `qn`.
- `valid`, out, 1: one-cycle pulse; `qn` and `qo` are new and `qo` is meaningful.

## Operation

- **Internal write pointer `wptr`:**
  - Advances by 1 on each accepted write.
  - Wraps to 0 after reaching `n`-1.
  - `n`=0 means a full-depth wrap at 2^`P_NBITS_ADDR`-1.
- **RAM address:** `addr` when `addr_en`=1 (and the macro is present), otherwise `wptr`. `wptr` keeps advancing in either mode.
- **Write cycle (read-before-write):** the old contents at the address go to `qo` and `d` is stored. In the same edge `qn` <= `d`.
- **Fill counter** (`P_NBITS_ADDR`+1 bits):
  - Counts accepted writes and saturates at the effective depth, which is `n`, or 2^`P_NBITS_ADDR` when `n`=0.
  - `valid` <= `wr` AND (fill == effective depth, before this write). So the first `n` writes after reset or flush produce no `valid`, and every write from the (`n`+1)th onward does.
- **Idle cycles** (`wr`=0): the RAM, `wptr`, `qn` and `qo` hold, and `valid`=0. Gaps between writes never change the delay.
- **`flush`=1:**
  - Next edge: `wptr`=0, fill=0, `valid`=0.
  - `flush` has priority over `wr`: a concurrent write is dropped (RAM not written, `qn`/`qo` hold).
- **`n` changes:** only take effect correctly after a flush. Without a flush the behaviour is defined only in that `wptr` wraps using the current `n`.
- **Reset:**
  - Clears `wptr`, fill, `qn`=0, `qo`=0, `valid`=0 immediately.
  - RAM contents are not cleared.
  - Reset in mid-stream behaves like a flush plus clearing the outputs.

## Timing

- Latency is 1 cycle: a write at edge k gives `qn`, `qo` and `valid` registered at edge k+1.
- All outputs are registered.
- The RAM is a synchronous read-first array, inferable as block RAM.
- Throughput is one write per cycle, sustained.

## Configuration

- Macro `RAM_DELAY_EXT_ADDR_EN`.
  - **Defined:** `addr_en`/`addr` select the external RAM address as described above.
  - **Undefined:** the `addr_en`/`addr` ports still exist but are ignored, and the RAM is always addressed by `wptr`.

## Structure

- Shared package `ram_delay_pkg`: default widths `P_NBITS_DATA`/`P_NBITS_ADDR`, and an `eff_depth(n)` function mapping `n`=0 to 2^`P_NBITS_ADDR`.
- One sub-module, `ram_delay_ram`: a parameterized single-port read-first synchronous RAM (`we`, `addr`, `din`, `dout`) with no reset.
- Pointer, fill counter and output registers live in `ram_delay`.

## Test plan

- **Fill and steady state:** reset held 10 cycles, `n`=16, 20 back-to-back writes of `d`=0..19.
  - `valid` stays low for writes 0..15.
  - Write of 16 gives `qn`=16, `qo`=0, `valid`=1. Write of 19 gives `qn`=19, `qo`=3.
  - `qo` = `qn`-16 always.
- **Gapped writes:** same stream with 1, 2, 3 and 4 idle cycles between bursts, and alternating write/idle.
  - `qo` = `qn`-16 on every `valid`.
  - `valid` is never high on idle cycles.
  - `qn` increments by 1 per `valid`.
- **External address:** `addr_en`=1, bench drives `addr` cycling 1..15,0 on each write, `n`=16.
  - Same `qo` = `qn`-16 relation after fill.
  - Without `RAM_DELAY_EXT_ADDR_EN`, results are identical to internal addressing.
- **Flush:** 20 writes of all-ones, then 16 cycles of `wr`=1 with `flush`=1, then `flush`=0.
  - `valid`=0 throughout the flush.
  - `qn` holds all-ones.
  - Next 16 writes give no `valid`; the 17th gives `valid`=1.
- **Reset mid-operation:** assert `rst` asynchronously between edges during steady state.
  - `qn`=`qo`=0 and `valid`=0 immediately.
  - After release, 16 writes are needed before `valid`.
- **Wrap-around at `n`=0 with `P_NBITS_ADDR`=4:** 17 writes of `d`=0..16.
  - The first `valid` comes with the 17th write, with `qo`=0 and `qn`=16.
